// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
//   Definitions shared by the serial word feeder (seq_serializer) and the
//   serial pair-detector bench.
//
//   Contents:
//     S_IDLE / S_SHIFT   : encodings of the serializer's two states
//     DEFAULT_SEQ_WIDTH  : default word width used by the feeder and its users
//     seq_state_t        : enum built on the encodings above
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    localparam int DEFAULT_SEQ_WIDTH = 16;

    typedef enum logic {
        IDLE  = S_IDLE,
        SHIFT = S_SHIFT
    } seq_state_t;

endpackage : seq_pkg

// File: rtl/seq_serializer.sv
// ----------------------------------------------------------------------------
// seq_serializer
//   Upstream feeder for the serial pair-detector FSM. Accepts WIDTH-bit words
//   over a valid/ready handshake and emits them one bit per clock on bit_out.
//   A shift register plus one holding register let back-to-back words stream
//   with no idle cycle between them. pause freezes the stream without losing
//   or repeating a bit.
//
//   Parameters:
//     WIDTH      bits per word (WIDTH >= 2)
//     LSB_FIRST  1: bit 0 goes out first (right shift)
//                0: bit WIDTH-1 goes out first (left shift)
//
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   asynchronous, active-high reset
//     load_valid  in   load_data holds a word this cycle
//     load_data   in   [WIDTH] parallel word to serialise
//     load_ready  out  a word can be taken (holding register is empty)
//     pause       in   freeze shifting; bit_valid is low while high
//     bit_out     out  current serial bit (drives the detector's inp)
//     bit_valid   out  bit_out is meaningful this cycle
//     last_bit    out  bit_out is the final bit of its word
//     busy        out  shifting a word or holding one
// ----------------------------------------------------------------------------
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_SEQ_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             pause,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] hbuf_q,  hbuf_d;
    logic             hfull_q, hfull_d;

    logic             accept;
    logic             at_last;
    logic             bypass_slot;
    logic [WIDTH-1:0] shifted;

    // The holding register is the only thing that can refuse a word: in IDLE
    // it is always empty, and in SHIFT a free holding register (or the
    // last-bit bypass) can always absorb the word.
    assign accept  = load_valid & ~hfull_q;
    assign at_last = (cnt_q == LAST_CNT);

    // The edge that retires the last bit of a word can take a new word
    // straight into sreg, as long as the stream is actually advancing.
    assign bypass_slot = (state_q == SHIFT) & ~pause & at_last;

    // Vacated bit positions fill with zero in either direction.
    assign shifted = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]}
                               : {sreg_q[WIDTH-2:0], 1'b0};

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here is defaulted to its held value first,
        // so no path through the case statement can leave one unassigned and
        // infer a latch.
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        hbuf_d  = hbuf_q;
        hfull_d = hfull_q;

        unique case (state_q)
            IDLE: begin
                // First bit is visible the cycle after this edge, even if
                // pause is high (bit_valid then waits for pause to fall).
                if (accept) begin
                    sreg_d  = load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (!pause) begin
                    if (!at_last) begin
                        sreg_d = shifted;
                        cnt_d  = cnt_q + 1'b1;
                    end else if (hfull_q) begin
                        // Held word follows with no gap; load_ready is low
                        // this cycle so no competing accept exists.
                        sreg_d  = hbuf_q;
                        hfull_d = 1'b0;
                        cnt_d   = '0;
                    end else if (accept) begin
                        sreg_d = load_data;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end

                // Any other accept while shifting parks the word.
                if (accept && !bypass_slot) begin
                    hbuf_d  = load_data;
                    hfull_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sreg and hbuf are cleared on reset as well as the control state:
    // bit_out is taken straight from sreg and must read 0 out of reset, and a
    // word held at reset time must never reappear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            hbuf_q  <= '0;
            hfull_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            hbuf_q  <= hbuf_d;
            hfull_q <= hfull_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign load_ready = ~hfull_q;
    assign bit_out    = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
    assign bit_valid  = (state_q == SHIFT) & ~pause;
    assign last_bit   = bit_valid & at_last;
    assign busy       = (state_q == SHIFT) | hfull_q;

endmodule : seq_serializer

// File: tb/tb_seq_serializer.sv
// ----------------------------------------------------------------------------
// tb_seq_serializer
//   Self-checking bench for seq_serializer. Two instances share clk, rst and
//   pause: u_lsb (LSB_FIRST=1) and u_msb (LSB_FIRST=0). Each accepted word
//   pushes its expected bit sequence into a per-instance queue; a negedge
//   monitor pops one entry per valid bit and compares bit_out and last_bit.
// ----------------------------------------------------------------------------
module tb_seq_serializer;

    localparam int W = 16;

    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pause = 1'b0;

    logic         lv_l = 1'b0, lv_m = 1'b0;
    logic [W-1:0] ld_l = '0,   ld_m = '0;
    logic         rdy_l, rdy_m;
    logic         bo_l, bo_m;
    logic         bv_l, bv_m;
    logic         lb_l, lb_m;
    logic         busy_l, busy_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sb_t q_l[$];
    sb_t q_m[$];

    int vcnt_l, first_l, last_l, lhit_l;
    int vcnt_m, lhit_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv_l),
        .load_data  (ld_l),
        .load_ready (rdy_l),
        .pause      (pause),
        .bit_out    (bo_l),
        .bit_valid  (bv_l),
        .last_bit   (lb_l),
        .busy       (busy_l)
    );

    seq_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv_m),
        .load_data  (ld_m),
        .load_ready (rdy_m),
        .pause      (pause),
        .bit_out    (bo_m),
        .bit_valid  (bv_m),
        .last_bit   (lb_m),
        .busy       (busy_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin : mon_lsb
        sb_t e;
        if (!rst && bv_l) begin
            vcnt_l++;
            if (first_l < 0) first_l = cyc;
            last_l = cyc;
            if (lb_l) lhit_l++;
            if (q_l.size() == 0) begin
                check("sb_underflow_lsb", 1, 0);
            end else begin
                e = q_l.pop_front();
                check("bit_lsb",  bo_l, e.b);
                check("last_lsb", lb_l, e.last);
            end
        end
    end

    always @(negedge clk) begin : mon_msb
        sb_t e;
        if (!rst && bv_m) begin
            vcnt_m++;
            if (lb_m) lhit_m++;
            if (q_m.size() == 0) begin
                check("sb_underflow_msb", 1, 0);
            end else begin
                e = q_m.pop_front();
                check("bit_msb",  bo_m, e.b);
                check("last_msb", lb_m, e.last);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        vcnt_l = 0; first_l = -1; last_l = -1; lhit_l = 0;
        vcnt_m = 0; lhit_m = 0;
    endtask

    task automatic push_word(input bit msb, input logic [W-1:0] w);
        sb_t e;
        for (int i = 0; i < W; i++) begin
            e.b    = msb ? w[W-1-i] : w[i];
            e.last = (i == W - 1);
            if (msb) q_m.push_back(e);
            else     q_l.push_back(e);
        end
    endtask

    // Presents a word, waits (bounded) for ready, returns just after the
    // accepting edge with load_valid dropped.
    task automatic send(input bit msb, input logic [W-1:0] w);
        int t = 0;
        if (msb) begin lv_m = 1'b1; ld_m = w; end
        else     begin lv_l = 1'b1; ld_l = w; end
        while (((msb ? rdy_m : rdy_l) !== 1'b1) && t < 100) begin
            step();
            t++;
        end
        if ((msb ? rdy_m : rdy_l) !== 1'b1) begin
            check("ready_timeout", 0, 1);
        end else begin
            push_word(msb, w);
            step();
        end
        if (msb) lv_m = 1'b0;
        else     lv_l = 1'b0;
    endtask

    task automatic wait_idle(input bit msb);
        int  t = 0;
        bit  done = 0;
        while (!done && t < 300) begin
            if (msb) done = (busy_m === 1'b0) && (q_m.size() == 0);
            else     done = (busy_l === 1'b0) && (q_l.size() == 0);
            if (!done) begin
                step();
                t++;
            end
        end
        check("idle_timeout", done, 1);
    endtask

    task automatic wait_vcnt(input int n);
        int t = 0;
        while (vcnt_l < n && t < 300) begin
            step();
            t++;
        end
        check("vcnt_timeout", (vcnt_l >= n), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bit_out"},    bo_l,   1'b0);
        check({tag, "_bit_valid"},  bv_l,   1'b0);
        check({tag, "_last_bit"},   lb_l,   1'b0);
        check({tag, "_load_ready"}, rdy_l,  1'b1);
        check({tag, "_busy"},       busy_l, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_stats();
        #1;
        check_reset_outputs("rst_hold");
        step();
        step();
        rst = 1'b0;
        step();
        check_reset_outputs("rst_rel");
        check("rst_rel_busy_msb", busy_m, 1'b0);

        // 1: single word, LSB first
        clear_stats();
        send(1'b0, 16'b0101011101110010);
        wait_idle(1'b0);
        check("t1_nbits",   vcnt_l, 16);
        check("t1_span",    last_l - first_l + 1, 16);
        check("t1_lasthit", lhit_l, 1);
        check("t1_valid0",  bv_l, 1'b0);

        // 2: back-to-back through the holding register
        clear_stats();
        send(1'b0, 16'h5772);
        send(1'b0, 16'hFFFF);
        check("t2_ready_held", rdy_l, 1'b0);
        check("t2_busy",       busy_l, 1'b1);
        wait_vcnt(16);
        check("t2_a_last",     lb_l, 1'b1);
        check("t2_ready_at_a_last", rdy_l, 1'b0);
        step();
        check("t2_ready_after", rdy_l, 1'b1);
        wait_idle(1'b0);
        check("t2_nbits",   vcnt_l, 32);
        check("t2_span",    last_l - first_l + 1, 32);
        check("t2_lasthit", lhit_l, 2);

        // 3: three-cycle pause in the middle of a word
        clear_stats();
        send(1'b0, 16'h5772);
        wait_vcnt(5);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_paused_valid", bv_l, 1'b0);
            check("t3_paused_last",  lb_l, 1'b0);
        end
        pause = 1'b0;
        wait_idle(1'b0);
        check("t3_nbits", vcnt_l, 16);
        check("t3_span",  last_l - first_l + 1, 19);

        // 4: bypass load on the last bit with the holding register empty
        clear_stats();
        send(1'b0, 16'h5772);
        wait_vcnt(16);
        check("t4_at_last", lb_l, 1'b1);
        send(1'b0, 16'hA5C3);
        check("t4_hfull_clear", rdy_l, 1'b1);
        check("t4_busy",        busy_l, 1'b1);
        wait_idle(1'b0);
        check("t4_nbits",   vcnt_l, 32);
        check("t4_span",    last_l - first_l + 1, 32);
        check("t4_lasthit", lhit_l, 2);

        // 5: asynchronous reset mid-word with a word held
        clear_stats();
        send(1'b0, 16'h5772);
        send(1'b0, 16'h1234);
        wait_vcnt(8);
        check("t5_hfull_before", rdy_l, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        q_l.delete();
        step();
        rst = 1'b0;
        step();
        clear_stats();
        send(1'b0, 16'h0F35);
        wait_idle(1'b0);
        check("t5_nbits",   vcnt_l, 16);
        check("t5_lasthit", lhit_l, 1);

        // 6: MSB-first instance
        clear_stats();
        send(1'b1, 16'h8001);
        wait_idle(1'b1);
        check("t6_nbits",   vcnt_m, 16);
        check("t6_lasthit", lhit_m, 1);
        check("t6_lsb_quiet", vcnt_l, 0);

        check("sb_leftover_lsb", q_l.size(), 0);
        check("sb_leftover_msb", q_m.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_serializer
